csa_accumulator: RTL and testbench
==================================

# csa_accumulator

Sequential final-adder and accumulator directly downstream of the 24:2 carry-save compressor tree. Each accepted beat takes one sum/carry pair, resolves it with a carry-propagate add, and adds it into a wide signed accumulator. After a programmed number of beats, the block presents one rounded-width dot-product result on a valid/ready output. Together with the compressor it forms a multi-beat MAC reduction path: 24 products per beat, up to 2^BEATS_W−1 beats.

## Interface
- IN_SIZE, 16, width of each carry-save input vector (two's complement)
- ACC_SIZE, 32, internal accumulator width; elaboration error if ACC_SIZE < IN_SIZE+1+BEATS_W
- OUT_SIZE, 24, result width; elaboration error if OUT_SIZE > ACC_SIZE
- BEATS_W, 8, width of beat-count field
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  one-cycle request to begin a reduction; honoured only in IDLE
- len_i  input  BEATS_W  number of beats, sampled with start_i
- in_valid_i  input  1  carry-save pair valid
- in_ready_o  output  1  block accepts a pair this cycle
- in_sum_i  input  IN_SIZE  compressor sum vector
- in_carry_i  input  IN_SIZE  compressor carry vector, already shifted
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- out_data_o  output  OUT_SIZE  signed result
- ovf_o  output  1  result was clamped; qualified by out_valid_o
- busy_o  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready_o=0, out_valid_o=0.
  - start_i && len_i≠0 → ACC, with acc_q←0 and remaining_q←len_i.
  - start_i && len_i==0 → DONE, with result 0 and ovf 0.
- ACC: in_ready_o=1. A beat is accepted only when in_valid_i && in_ready_o; idle cycles are allowed. On each accepted beat:
  - acc_q ← acc_q + sext(in_sum_i) + sext(in_carry_i), with both inputs sign-extended to ACC_SIZE.
  - remaining_q decrements by 1.
  - When remaining_q==1 at acceptance → DONE, and out_data_o/ovf_o are loaded from the updated accumulator value in the same edge.
- DONE: out_valid_o=1, in_ready_o=0. out_data_o and ovf_o are held stable until out_valid_o && out_ready_i. On that handshake → IDLE and acc_q←0.
- start_i outside IDLE is ignored, not queued.
- Width rule: ACC_SIZE is sized so the accumulator never wraps. Output conversion is described under Configuration.

## Timing
- Reset values: state IDLE, acc_q 0, remaining_q 0, in_ready_o 0, out_valid_o 0, out_data_o 0, ovf_o 0, busy_o 0.
- start_i at edge T → in_ready_o high in the cycle after T.
- Last beat accepted at edge N → out_valid_o high in the cycle after N, i.e. 1-cycle latency.
- Output handshake at edge M → in IDLE after M; a new start_i is honoured at edge M+1.
- Back-to-back throughput: one beat per cycle while in ACC.
- Reset asserted at any point (including mid-ACC or in DONE with valid high) immediately forces the reset values. Partial sums are discarded.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- Macro: AI_CORE_CSA_ACC_SAT_EN.
- Defined: out_data_o is acc_q clamped to [−2^(OUT_SIZE−1), 2^(OUT_SIZE−1)−1]. ovf_o=1 when clamping occurred.
- Undefined: out_data_o = acc_q[OUT_SIZE−1:0] (two's-complement wrap). ovf_o is tied to 0.

## Structure
- Package ai_core_acc_pkg holds:
  - the FSM state enum typedef (acc_state_t: IDLE, ACC, DONE);
  - the default width localparams;
  - a function computing the minimum legal ACC_SIZE.
- One sub-module: acc_saturator, a combinational ACC_SIZE→OUT_SIZE clamp that outputs ovf. It is instantiated only under AI_CORE_CSA_ACC_SAT_EN.

## Test plan
All scenarios use default parameters.
- **Single positive beat:** len=1, beat sum=0x0003, carry=0x0005 → out_valid_o one cycle after acceptance, out_data_o=0x000008, ovf_o=0.
- **Negative beats with gaps:** len=3, three beats of sum=0xFFFF, carry=0xFFFF, with in_valid_i low for 2 cycles between beats → exactly 3 beats counted, out_data_o=0xFFFFFA (−6).
- **Zero length:** len=0 → no in_ready_o, out_valid_o the next cycle, out_data_o=0.
- **Backpressure:** result pending, out_ready_i low for 5 cycles, start_i pulsed during that window → out_data_o stable, in_ready_o=0, start ignored. One cycle after out_ready_i rises, busy_o=0.
- **Overflow:** len=255, all beats sum=0x7FFF, carry=0x7FFF (total 16711170).
  - With AI_CORE_CSA_ACC_SAT_EN: out_data_o=0x7FFFFF, ovf_o=1.
  - Without it: out_data_o=0xFEFE02, ovf_o=0.
- **Mid-run reset:** len=4, two beats accepted, then rst_i pulsed → all outputs at reset values. Then len=1 with beat 1+1 → out_data_o=2.

Source files
------------

// File: rtl/ai_core_acc_pkg.sv
// Shared types and default widths for the carry-save accumulator datapath.
package ai_core_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam int DefInSize  = 16;
  localparam int DefAccSize = 32;
  localparam int DefOutSize = 24;
  localparam int DefBeatsW  = 8;

  // Narrowest accumulator that holds the worst-case sum of 2^beatsW-1 beats
  function automatic int minAccSize(input int inSize, input int beatsW);
    return inSize + 1 + beatsW;
  endfunction

endpackage

// File: rtl/acc_saturator.sv
// Combinational signed clamp from the wide accumulator to the result width,
// flagging when the value did not fit.
module acc_saturator #(
  parameter int ACC_SIZE = 32,
  parameter int OUT_SIZE = 24
) (
  input  logic [ACC_SIZE-1:0] acc_i,
  output logic [OUT_SIZE-1:0] data_o,
  output logic                ovf_o
);

  localparam logic [OUT_SIZE-1:0] MaxVal = {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] MinVal = {1'b1, {(OUT_SIZE-1){1'b0}}};

  logic [ACC_SIZE-OUT_SIZE:0] upperBits;

  // The value fits only if every bit above the result's sign bit matches it
  always_comb begin
    upperBits = acc_i[ACC_SIZE-1:OUT_SIZE-1];
    ovf_o     = !((&upperBits) || !(|upperBits));
    if (ovf_o) begin
      data_o = acc_i[ACC_SIZE-1] ? MinVal : MaxVal;
    end else begin
      data_o = acc_i[OUT_SIZE-1:0];
    end
  end

endmodule

// File: rtl/csa_accumulator.sv
// Multi-beat carry-save final adder and accumulator with a valid/ready result.
// Define AI_CORE_CSA_ACC_SAT_EN to clamp the result instead of wrapping it.
module csa_accumulator
  import ai_core_acc_pkg::*;
#(
  parameter int IN_SIZE  = DefInSize,
  parameter int ACC_SIZE = DefAccSize,
  parameter int OUT_SIZE = DefOutSize,
  parameter int BEATS_W  = DefBeatsW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [BEATS_W-1:0]  len_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_sum_i,
  input  logic [IN_SIZE-1:0]  in_carry_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_SIZE-1:0] out_data_o,
  output logic                ovf_o,
  output logic                busy_o
);

  if (ACC_SIZE < minAccSize(IN_SIZE, BEATS_W)) begin : gAccTooNarrow
    $error("csa_accumulator: ACC_SIZE too small for IN_SIZE and BEATS_W");
  end
  if (OUT_SIZE > ACC_SIZE) begin : gOutTooWide
    $error("csa_accumulator: OUT_SIZE exceeds ACC_SIZE");
  end

  acc_state_t          state_q, state_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [BEATS_W-1:0]  remaining_q, remaining_d;
  logic [OUT_SIZE-1:0] out_data_q, out_data_d;
  logic                ovf_q, ovf_d;

  logic [ACC_SIZE-1:0] accSum;
  logic [OUT_SIZE-1:0] convData;
  logic                convOvf;

  assign accSum = acc_q
                + {{(ACC_SIZE-IN_SIZE){in_sum_i[IN_SIZE-1]}}, in_sum_i}
                + {{(ACC_SIZE-IN_SIZE){in_carry_i[IN_SIZE-1]}}, in_carry_i};

`ifdef AI_CORE_CSA_ACC_SAT_EN
  acc_saturator #(
    .ACC_SIZE(ACC_SIZE),
    .OUT_SIZE(OUT_SIZE)
  ) u_sat (
    .acc_i (accSum),
    .data_o(convData),
    .ovf_o (convOvf)
  );
`else
  assign convData = accSum[OUT_SIZE-1:0];
  assign convOvf  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // The result registers load on the same edge as the final beat so the
  // value is presented one cycle after the last acceptance.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d = '0;
          if (len_i != '0) begin
            state_d     = ACC;
            remaining_d = len_i;
          end else begin
            state_d    = DONE;
            out_data_d = '0;
            ovf_d      = 1'b0;
          end
        end
      end
      ACC: begin
        if (in_valid_i) begin
          acc_d       = accSum;
          remaining_d = remaining_q - BEATS_W'(1);
          if (remaining_q == BEATS_W'(1)) begin
            state_d    = DONE;
            out_data_d = convData;
            ovf_d      = convOvf;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ACC);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    out_data_o  = out_data_q;
    ovf_o       = ovf_q;
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: directed scenarios plus randomized
// reductions, checked against a plain-arithmetic dot-product model.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inSum = '0;
  logic [15:0] inCarry = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [23:0] outData;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] data;
    logic        ovf;
  } exp_t;

  exp_t expQ[$];

  csa_accumulator dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_sum_i   (inSum),
    .in_carry_i (inCarry),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_data_o (outData),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion of an exact integer dot product to the result port
  function automatic exp_t convert(input longint total);
    exp_t e;
`ifdef AI_CORE_CSA_ACC_SAT_EN
    if (total > 64'sd8388607) begin
      e.data = 24'h7FFFFF;
      e.ovf  = 1'b1;
    end else if (total < -64'sd8388608) begin
      e.data = 24'h800000;
      e.ovf  = 1'b1;
    end else begin
      e.data = total[23:0];
      e.ovf  = 1'b0;
    end
`else
    e.data = total[23:0];
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Every cycle a result is offered it must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && outValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'(outValid), 32'd0);
      end else begin
        checkOutput("result_data", 32'(outData), 32'(expQ[0].data));
        checkOutput("result_ovf", 32'(ovf), 32'(expQ[0].ovf));
        if (outReady) void'(expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(inReady), 32'd0);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    expQ.delete();
    start = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Present one beat and hold it until accepted (bounded wait)
  task automatic sendBeat(input logic [15:0] s, input logic [15:0] c);
    bit accepted = 0;
    inSum = s;
    inCarry = c;
    inValid = 1'b1;
    for (int k = 0; k < 50 && !accepted; k++) begin
      accepted = inReady;
      tick();
    end
    inValid = 1'b0;
    if (!accepted) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  // One full reduction up to the point where the result is pending.
  // randData=0 uses the fixed sum/carry for every beat.
  task automatic applyStimulus(input int n, input bit randData, input logic [15:0] fs,
                               input logic [15:0] fc, input int maxGap);
    longint total = 0;
    logic [15:0] s, c;
    logic [15:0] sArr[$];
    logic [15:0] cArr[$];
    for (int i = 0; i < n; i++) begin
      s = randData ? 16'($urandom) : fs;
      c = randData ? 16'($urandom) : fc;
      sArr.push_back(s);
      cArr.push_back(c);
      total += longint'($signed(s)) + longint'($signed(c));
    end
    expQ.push_back(convert(total));
    start = 1'b1;
    len = 8'(n);
    tick();
    start = 1'b0;
    checkOutput("start_in_ready", 32'(inReady), (n != 0) ? 32'd1 : 32'd0);
    checkOutput("start_out_valid", 32'(outValid), (n == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) begin
      sendBeat(sArr[i], cArr[i]);
      if (i != n - 1) begin
        int g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        for (int j = 0; j < g; j++) begin
          tick();
          checkOutput("gap_out_valid", 32'(outValid), 32'd0);
        end
      end
    end
    checkOutput("result_latency", 32'(outValid), 32'd1);
  endtask

  // Hold the result for holdCycles, optionally pulsing start meanwhile, then accept it
  task automatic drain(input int holdCycles, input bit pulseStart);
    outReady = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      if (pulseStart && i == 1) begin
        start = 1'b1;
        len = 8'd5;
      end
      tick();
      start = 1'b0;
      checkOutput("hold_in_ready", 32'(inReady), 32'd0);
      checkOutput("hold_out_valid", 32'(outValid), 32'd1);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("drain_busy", 32'(busy), 32'd0);
    checkOutput("drain_out_valid", 32'(outValid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    applyReset();

    // Single positive beat: 3 + 5
    applyStimulus(1, 0, 16'h0003, 16'h0005, 0);
    checkOutput("single_literal", 32'(outData), 32'h000008);
    checkOutput("single_ovf", 32'(ovf), 32'd0);
    drain(0, 0);

    // Three negative beats separated by idle cycles
    applyStimulus(3, 0, 16'hFFFF, 16'hFFFF, 0);
    drain(0, 0);
    start = 1'b1;
    len = 8'd3;
    expQ.push_back(convert(-64'sd6));
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      sendBeat(16'hFFFF, 16'hFFFF);
      if (b != 2) begin
        tick();
        tick();
      end
    end
    checkOutput("neg_valid", 32'(outValid), 32'd1);
    checkOutput("neg_literal", 32'(outData), 32'hFFFFFA);
    drain(0, 0);

    // Zero length
    applyStimulus(0, 0, 16'h0, 16'h0, 0);
    checkOutput("zero_literal", 32'(outData), 32'h000000);
    drain(0, 0);

    // Backpressure with an ignored start pulse
    applyStimulus(2, 1, 16'h0, 16'h0, 1);
    drain(5, 1);
    tick();
    checkOutput("ignored_start_busy", 32'(busy), 32'd0);

    // Overflow: 255 beats of 0x7FFF + 0x7FFF
    applyStimulus(255, 0, 16'h7FFF, 16'h7FFF, 0);
`ifdef AI_CORE_CSA_ACC_SAT_EN
    checkOutput("ovf_literal", 32'(outData), 32'h7FFFFF);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
`else
    checkOutput("ovf_literal", 32'(outData), 32'hFEFE02);
    checkOutput("ovf_flag", 32'(ovf), 32'd0);
`endif
    drain(1, 0);

    // Mid-run reset discards partial sums
    start = 1'b1;
    len = 8'd4;
    tick();
    start = 1'b0;
    sendBeat(16'h0100, 16'h0100);
    sendBeat(16'h0100, 16'h0100);
    checkOutput("midrun_busy", 32'(busy), 32'd1);
    applyReset();
    applyStimulus(1, 0, 16'h0001, 16'h0001, 0);
    checkOutput("after_reset_literal", 32'(outData), 32'h000002);
    drain(0, 0);

    // Randomized reductions with random gaps and backpressure
    for (int r = 0; r < 25; r++) begin
      applyStimulus(int'($urandom_range(0, 20)), 1, 16'h0, 16'h0, 2);
      drain(int'($urandom_range(0, 3)), r[0]);
    end

    tick();
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
